// File: rtl/brick_frame_reader_pkg.sv
// Shared geometry, colours and scan-state encoding for the brick display reader.
package breakout_pkg;

  localparam int H       = 640;
  localparam int V       = 480;
  localparam int BRICK_W = 32;
  localparam int BRICK_H = 20;
  localparam int COLS    = 20;
  localparam int ROWS    = 24;
  localparam int BALL_W  = 16;
  localparam int BALL_H  = 10;
  localparam int BOARD_Y = 467;
  localparam int BOARD_W = 96;
  localparam int BOARD_H = 10;

  localparam int NBRICKS = COLS * ROWS;
  localparam int MAP_W   = 3 * NBRICKS;

  typedef logic [2:0] brick_code_t;

  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_DONE} scan_state_t;

  localparam logic [11:0] BALL_RGB  = 12'hFFF;
  localparam logic [11:0] BOARD_RGB = 12'hAAA;
  localparam logic [11:0] BG_RGB    = 12'h113;

  function automatic logic [11:0] palette_rgb(input brick_code_t code);
    logic [11:0] c;
    c = BG_RGB;
    case (code)
      3'd1: c = 12'hF00;
      3'd2: c = 12'hF80;
      3'd3: c = 12'hFF0;
      3'd4: c = 12'h0F0;
      3'd5: c = 12'h0FF;
      3'd6: c = 12'h00F;
      3'd7: c = 12'hF0F;
      default: c = BG_RGB;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/brick_frame_reader_if.sv
// Pixel-timing, game-state and result signals between the game core and the reader.
interface brick_frame_reader_if;
  import breakout_pkg::*;

  logic             pixel_en;
  logic             valid;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [MAP_W-1:0] bricks;
  logic [9:0]       ball_x;
  logic [9:0]       ball_y;
  logic [9:0]       board_x;
  logic [11:0]      rgb;
  logic [8:0]       brick_count;
  logic             count_valid;
  logic             level_clear;

  modport master (
    output pixel_en, valid, h_cnt, v_cnt, bricks, ball_x, ball_y, board_x,
    input  rgb, brick_count, count_valid, level_clear
  );

  modport slave (
    input  pixel_en, valid, h_cnt, v_cnt, bricks, ball_x, ball_y, board_x,
    output rgb, brick_count, count_valid, level_clear
  );
endinterface

// File: rtl/brick_frame_reader_counter.sv
// Walks the latched brick map one cell per clock and publishes the non-empty count.
module brick_counter
  import breakout_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [MAP_W-1:0] map_i,
  output logic [8:0]       count_o,
  output logic             count_valid_o,
  output logic             level_clear_o
);

  scan_state_t state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [8:0]  acc_q, acc_d;
  logic [8:0]  count_q, count_d;
  logic        cvalid_q, cvalid_d;
  logic [10:0] bit_idx;
  brick_code_t code;

  assign bit_idx = 11'(idx_q) * 11'd3;
  assign code    = map_i[bit_idx +: 3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    count_d       = count_q;
    cvalid_d      = cvalid_q;
    level_clear_o = 1'b0;
    case (state_q)
      SCAN_IDLE: begin
        if (start_i) begin
          state_d = SCAN_RUN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      SCAN_RUN: begin
        // A new frame latch abandons the partial count without publishing it.
        if (start_i) begin
          idx_d = '0;
          acc_d = '0;
        end else begin
          acc_d = acc_q + {8'd0, code != '0};
          idx_d = idx_q + 9'd1;
          if (idx_q == 9'(NBRICKS - 1)) state_d = SCAN_DONE;
        end
      end
      SCAN_DONE: begin
        count_d       = acc_q;
        cvalid_d      = 1'b1;
        level_clear_o = (acc_q == '0);
        if (start_i) begin
          state_d = SCAN_RUN;
          idx_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = SCAN_IDLE;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  assign count_o       = count_q;
  assign count_valid_o = cvalid_q;

endmodule

// File: rtl/brick_frame_reader.sv
// Latches game state once per frame and renders each pixel through a two-tick pipeline.
module brick_frame_reader
  import breakout_pkg::brick_code_t, breakout_pkg::palette_rgb,
         breakout_pkg::BALL_RGB, breakout_pkg::BOARD_RGB, breakout_pkg::BG_RGB;
#(
  parameter int H       = breakout_pkg::H,
  parameter int V       = breakout_pkg::V,
  parameter int BRICK_W = breakout_pkg::BRICK_W,
  parameter int BRICK_H = breakout_pkg::BRICK_H,
  parameter int COLS    = breakout_pkg::COLS,
  parameter int ROWS    = breakout_pkg::ROWS,
  parameter int BALL_W  = breakout_pkg::BALL_W,
  parameter int BALL_H  = breakout_pkg::BALL_H,
  parameter int BOARD_Y = breakout_pkg::BOARD_Y,
  parameter int BOARD_W = breakout_pkg::BOARD_W,
  parameter int BOARD_H = breakout_pkg::BOARD_H
) (
  input  logic                 clk,
  input  logic                 rst,
  brick_frame_reader_if.slave  bus
);

  localparam int          MAP_W     = 3 * COLS * ROWS;
  localparam logic [9:0]  BW        = 10'(BRICK_W);
  localparam logic [9:0]  BH        = 10'(BRICK_H);
  localparam logic [10:0] BOARD_TOP = 11'(BOARD_Y);
  localparam logic [10:0] BOARD_BOT = 11'(BOARD_Y + BOARD_H);

  logic             frame_latch;
  logic [MAP_W-1:0] map_q;
  logic [9:0]       ball_x_q, ball_y_q, board_x_q;
  logic             vld_p1_q;
  logic [9:0]       h_p1_q, v_p1_q;
  logic [9:0]       col, row, xo, yo;
  logic             in_grid, in_ball, in_board;
  logic [10:0]      cell_idx, sel_idx, bit_idx;
  logic [10:0]      hx, vy, bx, by, px;
  brick_code_t      code;
  logic [11:0]      rgb_q, rgb_d;
  logic [8:0]       count;
  logic             count_valid, level_clear;

  assign frame_latch = bus.pixel_en && (bus.h_cnt == '0) && (bus.v_cnt == 10'(V));

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q     <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      board_x_q <= '0;
    end else if (frame_latch) begin
      map_q     <= bus.bricks;
      ball_x_q  <= bus.ball_x;
      ball_y_q  <= bus.ball_y;
      board_x_q <= bus.board_x;
    end
  end

  // S1: register the coordinate
  always_ff @(posedge clk) begin
    if (rst)               vld_p1_q <= 1'b0;
    else if (bus.pixel_en) vld_p1_q <= bus.valid;
  end

  always_ff @(posedge clk) begin
    if (bus.pixel_en) begin
      h_p1_q <= bus.h_cnt;
      v_p1_q <= bus.v_cnt;
    end
  end

  // S2: locate the cell and compose the colour
  assign col      = h_p1_q / BW;
  assign row      = v_p1_q / BH;
  assign xo       = h_p1_q % BW;
  assign yo       = v_p1_q % BH;
  assign in_grid  = (col < 10'(COLS)) && (row < 10'(ROWS)) &&
                    (h_p1_q < 10'(H)) && (v_p1_q < 10'(V));
  assign cell_idx = 11'(col) + 11'(row) * 11'(COLS);
  assign sel_idx  = in_grid ? cell_idx : '0;
  assign bit_idx  = sel_idx * 11'd3;
  assign code     = in_grid ? map_q[bit_idx +: 3] : '0;

  // Widened sums keep x+W from wrapping near the top of the 10-bit range.
  assign hx = {1'b0, h_p1_q};
  assign vy = {1'b0, v_p1_q};
  assign bx = {1'b0, ball_x_q};
  assign by = {1'b0, ball_y_q};
  assign px = {1'b0, board_x_q};

  assign in_ball  = (hx >= bx) && (hx < bx + 11'(BALL_W)) &&
                    (vy >= by) && (vy < by + 11'(BALL_H));
  assign in_board = (hx >= px) && (hx < px + 11'(BOARD_W)) &&
                    (vy >= BOARD_TOP) && (vy < BOARD_BOT);

  always_comb begin
    rgb_d = BG_RGB;
    if (in_ball)
      rgb_d = BALL_RGB;
    else if (in_board)
      rgb_d = BOARD_RGB;
    else if ((code != '0) && (xo != BW - 10'd1) && (yo != BH - 10'd1))
      rgb_d = palette_rgb(code);
  end

  always_ff @(posedge clk) begin
    if (rst)               rgb_q <= '0;
    else if (bus.pixel_en) rgb_q <= vld_p1_q ? rgb_d : '0;
  end

  brick_counter u_counter (
    .clk           (clk),
    .rst           (rst),
    .start_i       (frame_latch),
    .map_i         (map_q),
    .count_o       (count),
    .count_valid_o (count_valid),
    .level_clear_o (level_clear)
  );

  assign bus.rgb         = rgb_q;
  assign bus.brick_count = count;
  assign bus.count_valid = count_valid;
  assign bus.level_clear = level_clear;

endmodule

// File: tb/tb_brick_frame_reader.sv
// Randomised bench for brick_frame_reader against a frame-level behavioural model.
module tb_brick_frame_reader;

  logic clk;
  logic rst;

  brick_frame_reader_if bus_if ();

  brick_frame_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;
  int cyc     = 0;

  // Bench-owned colour table and geometry
  localparam logic [11:0] T_BG    = 12'h113;
  localparam logic [11:0] T_BALL  = 12'hFFF;
  localparam logic [11:0] T_BOARD = 12'hAAA;
  logic [11:0] t_pal [8] = '{12'h113, 12'hF00, 12'hF80, 12'hFF0,
                             12'h0F0, 12'h0FF, 12'h00F, 12'hF0F};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_rgb(input bit vld, input int h, input int v,
                                          input logic [1439:0] map,
                                          input int bx, input int by, input int brd);
    int col, row;
    logic [2:0] c;
    if (!vld) return 12'h000;
    if (h >= bx && h < bx + 16 && v >= by && v < by + 10) return T_BALL;
    if (h >= brd && h < brd + 96 && v >= 467 && v < 477) return T_BOARD;
    col = h / 32;
    row = v / 20;
    if (col < 20 && row < 24) begin
      c = map[3 * (col + 20 * row) +: 3];
      if (c != 3'd0 && (h % 32) != 31 && (v % 20) != 19) return t_pal[c];
    end
    return T_BG;
  endfunction

  function automatic int count_nz(input logic [1439:0] map);
    int n = 0;
    for (int i = 0; i < 480; i++) if (map[3 * i +: 3] != 3'd0) n++;
    return n;
  endfunction

  // Frame-level model state
  logic [1439:0] m_map = '0;
  int   m_bx = 0, m_by = 0, m_brd = 0;
  bit   m_s1_vld = 0;
  int   m_s1_h = 0, m_s1_v = 0;
  logic [11:0] m_rgb = '0;
  bit   m_pend = 0;
  int   m_deadline = 0, m_scan_cnt = 0, m_count = 0, m_last_latch = 0;
  bit   m_cv = 0;

  wire tb_latch = bus_if.pixel_en && bus_if.h_cnt == 10'd0 && bus_if.v_cnt == 10'd480;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_map <= '0; m_bx <= 0; m_by <= 0; m_brd <= 0;
      m_s1_vld <= 0; m_rgb <= '0;
      m_pend <= 0; m_count <= 0; m_cv <= 0;
    end else begin
      if (bus_if.pixel_en) begin
        m_rgb    <= ref_rgb(m_s1_vld, m_s1_h, m_s1_v, m_map, m_bx, m_by, m_brd);
        m_s1_vld <= bus_if.valid;
        m_s1_h   <= int'(bus_if.h_cnt);
        m_s1_v   <= int'(bus_if.v_cnt);
      end
      if (tb_latch) begin
        m_map <= bus_if.bricks;
        m_bx  <= int'(bus_if.ball_x);
        m_by  <= int'(bus_if.ball_y);
        m_brd <= int'(bus_if.board_x);
        m_pend       <= 1;
        m_deadline   <= cyc + 481;
        m_scan_cnt   <= count_nz(bus_if.bricks);
        m_last_latch <= cyc;
      end
      if (m_pend && cyc == m_deadline) begin
        m_count <= m_scan_cnt;
        m_cv    <= 1;
        if (!tb_latch) m_pend <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rgb", 16'(bus_if.rgb), 16'(m_rgb));
      chk("brick_count", 16'(bus_if.brick_count), 16'(m_count));
      chk("count_valid", 16'(bus_if.count_valid), 16'(m_cv));
      chk("level_clear", 16'(bus_if.level_clear),
          16'(m_pend && cyc == m_deadline && m_scan_cnt == 0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int h, input int v, input bit val);
    @(negedge clk);
    bus_if.pixel_en = 1'b1;
    bus_if.h_cnt    = 10'(h);
    bus_if.v_cnt    = 10'(v);
    bus_if.valid    = val;
    @(negedge clk);
    bus_if.pixel_en = 1'b0;
  endtask

  task automatic latch();
    tick(0, 480, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_map(input int zero_pct);
    for (int i = 0; i < 480; i++)
      bus_if.bricks[3 * i +: 3] = ($urandom_range(0, 99) < zero_pct) ? 3'd0
                                  : 3'($urandom_range(1, 7));
  endtask

  function automatic int clampc(input int x);
    if (x < 0) return 0;
    if (x > 1023) return 1023;
    return x;
  endfunction

  initial begin
    int lc_seen, changes, h, v, pick;
    logic [8:0] prev;

    rst = 1'b1;
    bus_if.pixel_en = 1'b0; bus_if.valid = 1'b0;
    bus_if.h_cnt = '0; bus_if.v_cnt = '0; bus_if.bricks = '0;
    bus_if.ball_x = 10'd1000; bus_if.ball_y = 10'd1000; bus_if.board_x = 10'd1000;
    repeat (3) @(negedge clk);
    chk("reset_rgb", 16'(bus_if.rgb), 16'h0);
    chk("reset_count", 16'(bus_if.brick_count), 16'h0);
    chk("reset_cvalid", 16'(bus_if.count_valid), 16'h0);
    chk("reset_lclear", 16'(bus_if.level_clear), 16'h0);
    chk_on = 1'b1;
    rst = 1'b0;

    // Empty map: background everywhere and a level_clear 481 clk after the latch
    latch();
    lc_seen = -1;
    for (int i = 0; i < 600 && lc_seen < 0; i++) begin
      @(negedge clk);
      if (bus_if.level_clear) lc_seen = cyc;
    end
    chk("lclear_latency", 16'(lc_seen - m_last_latch), 16'd481);
    for (int i = 0; i < 40; i++)
      tick($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
    tick(10, 10, 1'b1);
    tick(20, 20, 1'b1);
    chk("empty_bg", 16'(bus_if.rgb), 16'(T_BG));
    chk("empty_count", 16'(bus_if.brick_count), 16'd0);
    chk("empty_cvalid", 16'(bus_if.count_valid), 16'd1);

    // Single brick in cell 0 with code 5
    bus_if.bricks = '0;
    bus_if.bricks[2:0] = 3'd5;
    latch();
    tick(5, 5, 1'b1);
    tick(31, 5, 1'b1);
    chk("brick5_colour", 16'(bus_if.rgb), 16'h0FF);
    tick(5, 19, 1'b1);
    chk("grout_col", 16'(bus_if.rgb), 16'(T_BG));
    tick(6, 6, 1'b1);
    chk("grout_row", 16'(bus_if.rgb), 16'(T_BG));
    idle(500);
    chk("one_brick_count", 16'(bus_if.brick_count), 16'd1);

    // Every cell occupied, with a second latch ~100 cells into the scan
    rand_map(0);
    prev = bus_if.brick_count;
    changes = 0;
    latch();
    for (int i = 0; i < 98; i++) begin
      @(negedge clk);
      if (bus_if.brick_count != prev) begin changes++; prev = bus_if.brick_count; end
    end
    latch();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus_if.brick_count != prev) begin changes++; prev = bus_if.brick_count; end
    end
    chk("full_count", 16'(bus_if.brick_count), 16'd480);
    chk("single_publish", 16'(changes), 16'd1);

    // Ball over a brick, board below it
    bus_if.bricks = '0;
    bus_if.bricks[3 * 103 +: 3] = 3'd2;
    bus_if.ball_x = 10'd100; bus_if.ball_y = 10'd100; bus_if.board_x = 10'd200;
    latch();
    tick(100, 100, 1'b1);
    tick(116, 100, 1'b1);
    chk("ball_over_brick", 16'(bus_if.rgb), 16'(T_BALL));
    tick(250, 470, 1'b1);
    chk("right_of_ball", 16'(bus_if.rgb), 16'hF80);
    tick(0, 0, 1'b0);
    chk("board", 16'(bus_if.rgb), 16'(T_BOARD));
    tick(0, 0, 1'b0);
    chk("invalid_black", 16'(bus_if.rgb), 16'h000);
    idle(500);

    // Random frames with a mid-frame change to the live inputs
    for (int f = 0; f < 3; f++) begin
      rand_map(30);
      bus_if.ball_x  = 10'($urandom_range(0, 639));
      bus_if.ball_y  = 10'($urandom_range(0, 479));
      bus_if.board_x = 10'($urandom_range(0, 639));
      latch();
      for (int t = 0; t < 150; t++) begin
        if (t == 75) begin
          rand_map(30);
          bus_if.ball_x = 10'($urandom_range(0, 639));
          bus_if.ball_y = 10'($urandom_range(0, 479));
        end
        pick = int'($urandom_range(0, 3));
        case (pick)
          0: begin h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 524)); end
          1: begin h = clampc(m_bx + int'($urandom_range(0, 19)) - 2);
                   v = clampc(m_by + int'($urandom_range(0, 13)) - 2); end
          2: begin h = clampc(m_brd + int'($urandom_range(0, 100)) - 2);
                   v = int'($urandom_range(464, 479)); end
          default: begin h = 32 * int'($urandom_range(0, 19)) + 31 - int'($urandom_range(0, 1));
                         v = 20 * int'($urandom_range(0, 23)) + 19 - int'($urandom_range(0, 1)); end
        endcase
        if (h == 0 && v == 480) h = 1;
        tick(h, v, (h < 640 && v < 480));
      end
      idle(500);
    end

    // Reset in the middle of a scan
    latch();
    tick(40, 40, 1'b1);
    tick(40, 40, 1'b1);
    idle(40);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cvalid", 16'(bus_if.count_valid), 16'd0);
    chk("rst_mid_rgb", 16'(bus_if.rgb), 16'd0);
    chk("rst_mid_count", 16'(bus_if.brick_count), 16'd0);
    rst = 1'b0;
    idle(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
